// File: rtl/adxl362_sequencer.sv
// ADXL362 command sequencer: configures the sensor over a byte-level SPI master,
// then periodically burst-reads X/Y/Z and publishes 12-bit samples.
`timescale 1ns/1ps
module adxl362_sequencer #(
  parameter int          SAMPLE_DIV     = 500000,
  parameter int          STARTUP_CYCLES = 2500000,
  parameter logic [7:0]  FILTER_CTL_VAL = 8'h13,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        clk_50_i,
  input  logic        reset_ni,
  input  logic        enable_i,
  output logic        spi_start_o,
  output logic [7:0]  spi_tx_byte_o,
  output logic        spi_cs_hold_o,
  input  logic        spi_busy_i,
  input  logic        spi_done_i,
  input  logic [7:0]  spi_rx_byte_i,
  output logic [11:0] x_acc_o,
  output logic [11:0] y_acc_o,
  output logic [11:0] z_acc_o,
  output logic        sample_valid_o,
  output logic        cfg_done_o,
  output logic        err_timeout_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_FILT, S_CFG_PWR, S_STARTUP, S_WAIT_TICK,
    S_RD_CMD, S_RD_ADDR, S_RD_DATA, S_PUBLISH
  } state_e;

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int STU_W = $clog2(STARTUP_CYCLES + 1);
  localparam int DIV_W = $clog2(SAMPLE_DIV + 1);

  state_e state_q, state_d;

  logic             in_flight_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [2:0]       byte_idx_q;
  logic [STU_W-1:0] startup_cnt_q;
  logic [DIV_W-1:0] tick_cnt_q;
  logic             pending_q;
  logic             cfg_done_q;
  logic             err_q;
  logic             start_q;
  logic [7:0]       tx_q;
  logic             cs_hold_q;
  logic [7:0]       lo_q [3];
  logic [3:0]       hi_q [2];
  logic [11:0]      x_q, y_q, z_q;
  logic             valid_q;

  // Combinational helpers
  logic       done_ok;
  logic       tmo_fire;
  logic       tick;
  logic       startup_last;
  logic       byte_state;
  logic [7:0] cur_byte;
  logic [2:0] last_idx;
  logic       last_byte;
  logic       cur_hold;
  logic       start_d;
  logic       data_done;
  logic       publish_evt;

  // A done pulse only counts when a byte is actually outstanding.
  assign done_ok      = spi_done_i & in_flight_q;
  assign tmo_fire     = in_flight_q & ~spi_done_i & (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign tick         = cfg_done_q & (tick_cnt_q == DIV_W'(SAMPLE_DIV - 1));
  assign startup_last = (state_q == S_STARTUP) & (startup_cnt_q == STU_W'(STARTUP_CYCLES - 1));
  assign data_done    = (state_q == S_RD_DATA) & done_ok;
  assign publish_evt  = data_done & last_byte;

  // State register
  always_ff @(posedge clk_50_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (tmo_fire) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      state_d = S_CFG_FILT;
        S_CFG_FILT:  if (done_ok && last_byte) state_d = S_CFG_PWR;
        S_CFG_PWR:   if (done_ok && last_byte) state_d = S_STARTUP;
        S_STARTUP:   if (startup_last) state_d = S_WAIT_TICK;
        S_WAIT_TICK: if (pending_q && enable_i) state_d = S_RD_CMD;
        S_RD_CMD:    if (done_ok && last_byte) state_d = S_RD_ADDR;
        S_RD_ADDR:   if (done_ok && last_byte) state_d = S_RD_DATA;
        S_RD_DATA:   if (done_ok && last_byte) state_d = S_PUBLISH;
        S_PUBLISH:   state_d = S_WAIT_TICK;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: byte table for the current state and the start request
  always_comb begin
    byte_state = 1'b1;
    cur_byte   = 8'h00;
    last_idx   = 3'd0;
    case (state_q)
      S_CFG_FILT: begin
        last_idx = 3'd2;
        case (byte_idx_q)
          3'd0:    cur_byte = 8'h0A;
          3'd1:    cur_byte = 8'h2C;
          default: cur_byte = FILTER_CTL_VAL;
        endcase
      end
      S_CFG_PWR: begin
        last_idx = 3'd2;
        case (byte_idx_q)
          3'd0:    cur_byte = 8'h0A;
          3'd1:    cur_byte = 8'h2D;
          default: cur_byte = 8'h02;
        endcase
      end
      S_RD_CMD:  cur_byte = 8'h0B;
      S_RD_ADDR: cur_byte = 8'h0E;
      S_RD_DATA: last_idx = 3'd5;
      default:   byte_state = 1'b0;
    endcase
    last_byte = (byte_idx_q == last_idx);
    // Chip select is released only after the final byte of a config write or ZH.
    cur_hold  = ~((state_q == S_CFG_FILT || state_q == S_CFG_PWR || state_q == S_RD_DATA) && last_byte);
    start_d   = byte_state & ~in_flight_q & ~spi_busy_i;
  end

  // Byte handshake, timeout and sequencing counters
  always_ff @(posedge clk_50_i or negedge reset_ni) begin
    if (!reset_ni) begin
      in_flight_q   <= 1'b0;
      tmo_cnt_q     <= '0;
      byte_idx_q    <= '0;
      startup_cnt_q <= '0;
      tick_cnt_q    <= '0;
      pending_q     <= 1'b0;
      cfg_done_q    <= 1'b0;
      err_q         <= 1'b0;
      start_q       <= 1'b0;
      tx_q          <= '0;
      cs_hold_q     <= 1'b0;
    end else begin
      start_q <= start_d;

      if (tmo_fire)     in_flight_q <= 1'b0;
      else if (start_d) in_flight_q <= 1'b1;
      else if (done_ok) in_flight_q <= 1'b0;

      if (start_d)          tmo_cnt_q <= '0;
      else if (in_flight_q) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);

      if (start_d) tx_q <= cur_byte;

      if (tmo_fire)     cs_hold_q <= 1'b0;
      else if (start_d) cs_hold_q <= cur_hold;

      if (state_d != state_q) byte_idx_q <= '0;
      else if (done_ok)       byte_idx_q <= byte_idx_q + 3'd1;

      if (state_q == S_STARTUP) startup_cnt_q <= startup_cnt_q + STU_W'(1);
      else                      startup_cnt_q <= '0;

      if (tmo_fire)          cfg_done_q <= 1'b0;
      else if (startup_last) cfg_done_q <= 1'b1;

      if (tmo_fire) err_q <= 1'b1;

      // The sample timebase only runs while configuration is complete.
      if (!cfg_done_q || tick) tick_cnt_q <= '0;
      else                     tick_cnt_q <= tick_cnt_q + DIV_W'(1);

      if (tmo_fire)                              pending_q <= 1'b0;
      else if (tick)                             pending_q <= 1'b1;
      else if (start_d && state_q == S_RD_CMD)   pending_q <= 1'b0;
    end
  end

  // Sample capture and publication
  always_ff @(posedge clk_50_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < 3; i++) lo_q[i] <= '0;
      for (int i = 0; i < 2; i++) hi_q[i] <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (data_done && byte_idx_q == 3'(2 * i)) lo_q[i] <= spi_rx_byte_i;
      for (int i = 0; i < 2; i++)
        if (data_done && byte_idx_q == 3'(2 * i + 1)) hi_q[i] <= spi_rx_byte_i[3:0];
      // ZH arrives on the publishing edge, so Z is assembled straight from the bus.
      if (publish_evt) begin
        x_q <= {hi_q[0], lo_q[0]};
        y_q <= {hi_q[1], lo_q[1]};
        z_q <= {spi_rx_byte_i[3:0], lo_q[2]};
      end
      valid_q <= publish_evt;
    end
  end

  assign spi_start_o    = start_q;
  assign spi_tx_byte_o  = tx_q;
  assign spi_cs_hold_o  = cs_hold_q;
  assign x_acc_o        = x_q;
  assign y_acc_o        = y_q;
  assign z_acc_o        = z_q;
  assign sample_valid_o = valid_q;
  assign cfg_done_o     = cfg_done_q;
  assign err_timeout_o  = err_q;

endmodule

// File: doc/adxl362_sequencer.md
Name: adxl362_sequencer

Overview:
Command sequencer for the ADXL362 accelerometer path, clocked in the clk_50 domain. After reset it drives a byte-level SPI master through the configuration writes, waits out sensor start-up, then issues periodic X/Y/Z burst reads. It assembles 12-bit two's-complement samples and publishes each complete triple with a one-cycle valid strobe. It owns the single SPI resource and is the only agent that issues SPI transactions.

Parameters:
SAMPLE_DIV, 500000, clk_50 cycles between sample ticks (100 Hz at 50 MHz); minimum 64
STARTUP_CYCLES, 2500000, wait after POWER_CTL write before the first read (50 ms)
FILTER_CTL_VAL, 8'h13, byte written to FILTER_CTL 0x2C (±2 g, 100 Hz ODR)
TIMEOUT_CYCLES, 4096, maximum cycles from spi_start to spi_done

Ports:
clk_50  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  permits sample reads; configuration runs regardless
spi_start  out  1  one-cycle request to shift spi_tx_byte
spi_tx_byte  out  8  byte to transmit; held stable from spi_start until spi_done
spi_cs_hold  out  1  1 = keep n_CS low after this byte; 0 = last byte of transaction
spi_busy  in  1  SPI master busy
spi_done  in  1  one-cycle pulse when a byte completes
spi_rx_byte  in  8  received byte, valid with spi_done
x_acc, y_acc, z_acc  out  12  latest samples, two's complement
sample_valid  out  1  one-cycle pulse when x/y/z update
cfg_done  out  1  high once configuration and start-up wait are complete
err_timeout  out  1  sticky SPI timeout flag

Behaviour:
- Reset (reset low): state IDLE. All outputs are 0: spi_start, spi_tx_byte, spi_cs_hold, x/y/z_acc, sample_valid, cfg_done and err_timeout. Counters are cleared. Reset asserted mid-transaction aborts immediately; no completion is awaited.
- Byte handshake: spi_start is pulsed only when spi_busy=0 and no byte is in flight. At most one byte is outstanding. The next byte is started no earlier than the cycle after spi_done.
- States:
  - IDLE: leave on the first cycle after reset is released.
  - CFG_FILT: sends 0x0A, 0x2C, FILTER_CTL_VAL.
  - CFG_PWR: sends 0x0A, 0x2D, 0x02 (measurement mode).
  - STARTUP: counts STARTUP_CYCLES. cfg_done rises on the last count and stays high until reset.
  - WAIT_TICK: a read starts when a tick is pending and enable=1.
  - RD_CMD: sends 0x0B.
  - RD_ADDR: sends 0x0E.
  - RD_DATA: sends six 0x00 bytes and captures XL, XH, YL, YH, ZL, ZH in that order.
  - PUBLISH: one cycle, then back to WAIT_TICK.
- spi_cs_hold is 1 for every byte except the final byte of each transaction: the third config byte and ZH.
- Tick counter:
  - Starts when cfg_done rises and free-runs, producing a tick every SAMPLE_DIV cycles.
  - A tick arriving during a read, or while enable=0, sets a single pending flag. Further ticks while the flag is set are dropped.
  - The flag clears when RD_CMD's spi_start issues.
- enable falling mid-read: the current burst completes and publishes. No new read starts until enable=1. The pending flag is retained.
- Assembly: axis = {H[3:0], L[7:0]}; H[7:4] is ignored.
- PUBLISH timing:
  - PUBLISH is the cycle after the ZH spi_done.
  - In PUBLISH, x/y/z_acc update together and sample_valid is high for exactly that cycle.
  - Outputs hold between publishes.
  - Partial bursts never update outputs.
- Timeout:
  - If spi_done has not arrived TIMEOUT_CYCLES after spi_start, err_timeout is set (sticky until reset), spi_cs_hold drops to 0 and the state goes to IDLE.
  - The sequence then re-runs configuration from CFG_FILT. cfg_done is cleared. Outputs retain their last published values.
- spi_done received with no byte outstanding is ignored.

Test Plan:
- Release reset, SPI model acknowledges each byte after 20 cycles -> tx sequence 0A 2C 13 (cs_hold 1,1,0), then 0A 2D 02 (1,1,0); cfg_done rises STARTUP_CYCLES after the last spi_done.
- Override SAMPLE_DIV=200 and STARTUP_CYCLES=100; model returns 0x34,0x02,0xFF,0xFF,0x00,0xF8 -> x=0x234, y=0xFFF, z=0x800; sample_valid high for exactly 1 cycle, the cycle after the ZH spi_done; tx 0B 0E then six 00 bytes.
- Model latency of 300 cycles (longer than SAMPLE_DIV) -> back-to-back reads with at most one pending tick; no overlapping spi_start; every burst publishes.
- Model withholds spi_done on byte 5 of a read -> err_timeout=1 after 4096 cycles, cs_hold=0, configuration re-sent starting with 0A 2C; x/y/z unchanged.
- Drop enable during RD_DATA -> burst finishes and publishes once; no RD_CMD until enable returns; the pending read starts within 2 cycles of enable rising.
- Assert reset during RD_ADDR -> all outputs 0 within the same cycle; after release the sequence restarts at CFG_FILT.
